// File: rtl/spi16_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi16_master : 16-bit SPI mode-0 initiator, MSB first, one word per nSS frame
// Revision 1.0
// ----------------------------------------------------------------------------
module spi16_master #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned MIN_GAP     = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done,
  output logic        nSS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [7:0] c_HALF_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] c_SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] c_HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] c_GAP_LAST   = 8'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [14:0] tx_q;
  logic [15:0] rx_q;
  logic [15:0] dout_q;
  logic        miso_q;
  logic        busy_q;
  logic        done_q;
  logic        nss_q;
  logic        sclk_q;
  logic        mosi_q;

  logic [7:0]  cnt_lim;
  logic        cnt_end;

  // Every timed state runs its phase counter from 0 up to its own limit.
  always_comb begin
    cnt_lim = c_HALF_LAST;
    case (state_q)
      SETUP:   cnt_lim = c_SETUP_LAST;
      HOLD:    cnt_lim = c_HOLD_LAST;
      GAP:     cnt_lim = c_GAP_LAST;
      default: cnt_lim = c_HALF_LAST;
    endcase
  end

  assign cnt_end = (cnt_q == cnt_lim);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      tx_q    <= 15'd0;
      rx_q    <= 16'd0;
      dout_q  <= 16'd0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nss_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      miso_q <= MISO;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q    <= din[14:0];
            mosi_q  <= din[15];
            nss_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_end) begin
            cnt_q   <= 8'd0;
            state_q <= SHIFT_LO;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        SHIFT_LO: begin
          if (cnt_end) begin
            cnt_q   <= 8'd0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HI;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        SHIFT_HI: begin
          if (cnt_end) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
            rx_q   <= {rx_q[14:0], miso_q};
            // MOSI only moves together with the falling SCLK edge.
            if (bit_q == 4'd15) begin
              mosi_q  <= 1'b0;
              state_q <= HOLD;
            end else begin
              bit_q   <= bit_q + 4'd1;
              mosi_q  <= tx_q[14];
              tx_q    <= {tx_q[13:0], 1'b0};
              state_q <= SHIFT_LO;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        HOLD: begin
          if (cnt_end) begin
            cnt_q   <= 8'd0;
            nss_q   <= 1'b1;
            dout_q  <= rx_q;
            done_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        GAP: begin
          // The done cycle is the first gap cycle.
          if (cnt_end) begin
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          cnt_q   <= 8'd0;
          bit_q   <= 4'd0;
          nss_q   <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign nSS  = nss_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi16_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi16_master : directed self-checking bench for spi16_master
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_spi16_master;

  logic        clk   = 1'b0;
  logic        res_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] din   = 16'h0000;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic        nSS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO  = 1'b0;

  logic        start2 = 1'b0;
  logic [15:0] din2   = 16'h0000;
  logic [15:0] dout2;
  logic        busy2;
  logic        done2;
  logic        nss2;
  logic        sclk2;
  logic        mosi2;
  logic        miso2  = 1'b0;

  spi16_master dut (
    .clk(clk), .res_n(res_n), .start(start), .din(din), .dout(dout),
    .busy(busy), .done(done), .nSS(nSS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  spi16_master #(.HALF_PERIOD(2), .CS_SETUP(1), .CS_HOLD(1), .MIN_GAP(1)) dut2 (
    .clk(clk), .res_n(res_n), .start(start2), .din(din2), .dout(dout2),
    .busy(busy2), .done(done2), .nSS(nss2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  int          done_cnt = 0, done_cyc = 0, done2_cnt = 0, done2_cyc = 0;
  int          rises = 0, falls = 0, bad = 0, last_rise = 0;
  int          min_hi = 999, max_hi = 0, min_per = 999, max_per = 0;
  int          s_idx = 0;
  logic [15:0] s_word = 16'h0000;
  logic [15:0] mosi_cap = 16'h0000, mosi2_cap = 16'h0000;
  logic        sclk_prev = 1'b0, nss_prev = 1'b1, mosi_prev = 1'b0, sclk2_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Bus monitor plus a mode-0 slave that shifts s_word out MSB first.
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    if (nss_prev && !nSS) begin
      s_idx = 0;
      MISO  = s_word[15];
    end
    if (SCLK && !sclk_prev) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], MOSI};
      if (nss_prev || (MOSI !== mosi_prev)) bad++;
      if (rises > 1) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (!SCLK && sclk_prev) begin
      falls++;
      if (nss_prev) bad++;
      if (cyc - last_rise < min_hi) min_hi = cyc - last_rise;
      if (cyc - last_rise > max_hi) max_hi = cyc - last_rise;
      s_idx++;
      MISO = (s_idx < 16) ? s_word[15 - s_idx] : 1'b0;
    end
    if (sclk2 && !sclk2_prev) mosi2_cap = {mosi2_cap[14:0], mosi2};
    sclk_prev  = SCLK;
    nss_prev   = nSS;
    mosi_prev  = MOSI;
    sclk2_prev = sclk2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    done_cnt = 0; rises = 0; falls = 0; bad = 0;
    min_hi = 999; max_hi = 0; min_per = 999; max_per = 0;
  endtask

  task automatic launch(input logic [15:0] w, output int t0);
    din   = w;
    start = 1'b1;
    tick();
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) tick();
    check("done_seen", done_cnt, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    check("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  int          t0, t_evt;
  logic [15:0] prev_w;
  logic [15:0] words [3];
  logic [15:0] echo  [3];

  initial begin
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h1234;
    echo[0]  = 16'h0000; echo[1]  = 16'h0000; echo[2]  = 16'hFFFF;

    // Reset, then idle
    repeat (3) tick();
    res_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    check("rst_nss",   {31'd0, nSS},  32'd1);
    check("rst_sclk",  {31'd0, SCLK}, 32'd0);
    check("rst_mosi",  {31'd0, MOSI}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  done_cnt, 0);
    check("rst_dout",  {16'd0, dout}, 32'h0000);
    check("rst_edges", rises + falls, 0);
    check("rst_dout2", {16'd0, dout2}, 32'h0000);

    // Single default frame A5C3 / 3C5A
    clear_mon();
    s_word = 16'h3C5A;
    launch(16'hA5C3, t0);
    din = 16'h0000;
    wait_done(1);
    check("f1_done_lat", done_cyc - t0, 132);
    check("f1_dout",     {16'd0, dout}, 32'h3C5A);
    check("f1_mosi",     {16'd0, mosi_cap}, 32'hA5C3);
    check("f1_rises",    rises, 16);
    check("f1_falls",    falls, 16);
    check("f1_hi_min",   min_hi, 4);
    check("f1_hi_max",   max_hi, 4);
    check("f1_per_min",  min_per, 8);
    check("f1_per_max",  max_per, 8);
    check("f1_bad",      bad, 0);
    wait_idle();
    check("f1_busy_lat", cyc - t0, 134);
    repeat (5) tick();
    check("f1_one_done", done_cnt, 1);

    // start held high; din changes mid-frame
    clear_mon();
    s_word = 16'h0000;
    din    = 16'hFFFF;
    start  = 1'b1;
    tick();
    t0  = cyc;
    din = 16'h0001;
    wait_done(1);
    check("hold_mosi", {16'd0, mosi_cap}, 32'hFFFF);
    s_word = 16'hBEEF;
    for (int i = 0; i < 20 && nSS; i++) tick();
    t_evt = cyc;
    start = 1'b0;
    check("hold_restart", t_evt - t0, 135);
    check("hold_nss_gap", t_evt - done_cyc, 3);
    wait_done(2);
    check("hold_mosi2", {16'd0, mosi_cap}, 32'h0001);
    check("hold_dout2", {16'd0, dout}, 32'hBEEF);
    wait_idle();

    // Fast parameter set on the second instance
    done2_cnt = 0;
    miso2  = 1'b1;
    din2   = 16'h8001;
    start2 = 1'b1;
    tick();
    t0     = cyc;
    start2 = 1'b0;
    for (int i = 0; i < 200 && done2_cnt < 1; i++) tick();
    check("fast_done_lat", done2_cyc - t0, 66);
    check("fast_dout",     {16'd0, dout2}, 32'hFFFF);
    check("fast_mosi",     {16'd0, mosi2_cap}, 32'h8001);
    for (int i = 0; i < 20 && busy2; i++) tick();
    check("fast_busy_lat", cyc - t0, 67);
    miso2  = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 200 && done2_cnt < 2; i++) tick();
    check("fast_done2",    done2_cnt, 2);
    check("fast_dout0",    {16'd0, dout2}, 32'h0000);

    // Reset in the middle of a frame
    clear_mon();
    s_word = 16'hFFFF;
    launch(16'h1234, t0);
    for (int i = 0; i < 200 && rises < 7; i++) tick();
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    check("mid_nss",  {31'd0, nSS},  32'd1);
    check("mid_sclk", {31'd0, SCLK}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_dout", {16'd0, dout}, 32'h0000);
    repeat (200) tick();
    check("mid_no_done", done_cnt, 0);
    clear_mon();
    s_word = 16'h1357;
    launch(16'h0F0F, t0);
    wait_done(1);
    check("mid_new_dout", {16'd0, dout}, 32'h1357);
    check("mid_new_mosi", {16'd0, mosi_cap}, 32'h0F0F);
    wait_idle();

    // Back-to-back frames, slave echoes the previous word
    clear_mon();
    prev_w = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      s_word = prev_w;
      launch(words[k], t0);
      wait_done(k + 1);
      check("b2b_dout", {16'd0, dout}, {16'd0, echo[k]});
      prev_w = words[k];
      wait_idle();
    end
    repeat (50) tick();
    check("b2b_dones", done_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
